// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the oversampled SPI slave.
//   state_e          - frame FSM states
//   SPI_MODE0..3     - {CPOL,CPHA} pairs for the four SPI modes
//   lead_is_rise()   - polarity of the leading SCLK edge for a given CPOL
package spi_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2,
      DONE      = 2'd3
   } state_e;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   // Leading edge leaves the idle level: rising when SCLK idles low.
   function automatic logic lead_is_rise(input logic cpol);
      return ~cpol;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchroniser for an asynchronous pin plus
// rise/fall detection on the synchronised value.
//   clock, reset - system clock, async active-high reset
//   din          - asynchronous pin
//   dout         - synchronised pin value
//   rise, fall   - one-cycle pulses comparing the last two synchronised samples
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Next values of the synchroniser chain and the edge-history flop.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   // Synchroniser and history registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave running in the system clock domain. SCLK, SSEL and
// MOSI are oversampled; all four CPOL/CPHA modes, MSB/LSB-first order.
//   clock, reset          - system clock, async active-high reset
//   sclk, ssel, mosi      - asynchronous SPI pins (ssel active-low)
//   miso, miso_oe         - registered slave output and pad enable
//   tx_data/valid/ready   - one-entry transmit buffer handshake
//   rx_data/valid/ready   - received-word handshake
//   busy                  - selected and framing (SHIFT or DONE)
//   overrun, underrun, frame_err - sticky flags, cleared by clear_flags
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int WIDTH       = 10,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int LSB_FIRST   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sclk,
   input  logic             ssel,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             busy,
   output logic             overrun,
   output logic             underrun,
   output logic             frame_err,
   input  logic             clear_flags
);

   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int WCNT_W = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(SYNC_STAGES + 1);
   // Sampling uses the leading edge for CPHA=0 and the trailing edge for CPHA=1.
   localparam logic SAMPLE_RISE = (CPHA != 0) ? ~lead_is_rise(CPOL != 0)
                                              :  lead_is_rise(CPOL != 0);

   logic sclk_s, sclk_rise, sclk_fall;
   logic ssel_s, ssel_rise, ssel_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;
   logic sample_ev, drive_ev;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sync_sclk (
      .clock(clock), .reset(reset), .din(sclk),
      .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
      .clock(clock), .reset(reset), .din(ssel),
      .dout(ssel_s), .rise(ssel_rise), .fall(ssel_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clock(clock), .reset(reset), .din(mosi),
      .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   assign sample_ev = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign drive_ev  = SAMPLE_RISE ? sclk_fall : sclk_rise;

   // Bit currently presented from a transmit word.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
   endfunction

   // Transmit word after one bit has gone out; ones fill the vacated end.
   function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] w);
      return (LSB_FIRST != 0) ? {1'b1, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b1};
   endfunction

   // Receive word after one mosi bit has been taken in.
   function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] w, input logic b);
      return (LSB_FIRST != 0) ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
   endfunction

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  tx_sreg_q, tx_sreg_d, rx_sreg_q, rx_sreg_d;
   logic [WIDTH-1:0]  txbuf_q, txbuf_d, rx_data_q, rx_data_d;
   logic              tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
   logic              miso_q, miso_d, miso_oe_q, miso_oe_d, busy_q, busy_d;
   logic              overrun_q, overrun_d, underrun_q, underrun_d;
   logic              frame_err_q, frame_err_d, present_q, present_d;
   logic [WIDTH-1:0]  start_word_s, rx_word_s;
   logic              ovr_set_s, und_set_s, ferr_set_s;

   // Frame FSM, buffers, handshakes and sticky flags.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      cnt_d        = cnt_q;
      tx_sreg_d    = tx_sreg_q;
      rx_sreg_d    = rx_sreg_q;
      txbuf_d      = txbuf_q;
      tx_ready_d   = tx_ready_q;
      rx_data_d    = rx_data_q;
      miso_d       = miso_q;
      miso_oe_d    = miso_oe_q;
      busy_d       = busy_q;
      present_d    = 1'b0;
      start_word_s = txbuf_q;
      rx_word_s    = shift_rx(rx_sreg_q, mosi_s);
      ovr_set_s    = 1'b0;
      und_set_s    = 1'b0;
      ferr_set_s   = 1'b0;

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      else                        rx_valid_d = rx_valid_q;

      case (state_q)
         // Let the synchronisers flush, then require ssel high before arming,
         // so a select already low at reset never starts a frame.
         WAIT_IDLE: begin
            if (wait_cnt_q != WAIT_LAST) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            else if (ssel_s)             state_d = IDLE;
            else                         state_d = WAIT_IDLE;
         end
         IDLE: begin
            if (ssel_fall) begin
               if (tx_ready_q) begin
                  start_word_s = {WIDTH{1'b1}};
                  und_set_s    = 1'b1;
               end else begin
                  start_word_s = txbuf_q;
               end
               tx_ready_d = 1'b1;
               cnt_d      = '0;
               rx_sreg_d  = '0;
               busy_d     = 1'b1;
               miso_oe_d  = 1'b1;
               state_d    = SHIFT;
               // CPHA=0 presents the first bit before any SCLK edge.
               if (CPHA == 0) begin
                  miso_d    = out_bit(start_word_s);
                  tx_sreg_d = shift_tx(start_word_s);
               end else begin
                  tx_sreg_d = start_word_s;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (ssel_rise) begin
               ferr_set_s = 1'b1;
               busy_d     = 1'b0;
               miso_oe_d  = 1'b0;
               state_d    = IDLE;
            end else begin
               // A drive edge updates miso one cycle after it is detected.
               if (present_q) begin
                  miso_d    = out_bit(tx_sreg_q);
                  tx_sreg_d = shift_tx(tx_sreg_q);
               end else begin
                  tx_sreg_d = tx_sreg_q;
               end
               present_d = drive_ev;
               if (sample_ev) begin
                  rx_sreg_d = rx_word_s;
                  cnt_d     = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     state_d = DONE;
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = rx_word_s;
                        rx_valid_d = 1'b1;
                     end else begin
                        ovr_set_s = 1'b1;
                     end
                  end else begin
                     state_d = SHIFT;
                  end
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         DONE: begin
            if (ssel_rise) begin
               busy_d    = 1'b0;
               miso_oe_d = 1'b0;
               state_d   = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = WAIT_IDLE;
      endcase

      // A load in the frame-start cycle is for the next frame.
      if (tx_valid && tx_ready_q) begin
         txbuf_d    = tx_data;
         tx_ready_d = 1'b0;
      end else begin
         txbuf_d = txbuf_q;
      end

      // Set events win over a simultaneous clear.
      if (ovr_set_s)        overrun_d = 1'b1;
      else if (clear_flags) overrun_d = 1'b0;
      else                  overrun_d = overrun_q;
      if (und_set_s)        underrun_d = 1'b1;
      else if (clear_flags) underrun_d = 1'b0;
      else                  underrun_d = underrun_q;
      if (ferr_set_s)       frame_err_d = 1'b1;
      else if (clear_flags) frame_err_d = 1'b0;
      else                  frame_err_d = frame_err_q;
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_IDLE;
         wait_cnt_q  <= '0;
         cnt_q       <= '0;
         tx_sreg_q   <= '0;
         rx_sreg_q   <= '0;
         txbuf_q     <= '0;
         tx_ready_q  <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         miso_q      <= 1'b1;
         miso_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
         present_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         cnt_q       <= cnt_d;
         tx_sreg_q   <= tx_sreg_d;
         rx_sreg_q   <= rx_sreg_d;
         txbuf_q     <= txbuf_d;
         tx_ready_q  <= tx_ready_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
         present_q   <= present_d;
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign tx_ready  = tx_ready_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign underrun  = underrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed bench for spi_slave_sync. Four instances cover
// mode 0 (MSB), mode 1 (MSB), mode 2 (LSB-first) and mode 3 (LSB-first); the
// mode-0 instance also exercises flags, handshakes and mid-frame reset.
module tb_spi_slave_sync;

   localparam int W = 10;
   localparam int H = 6;   // SCLK half period in system clocks

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic         sclk_a [4];
   logic         ssel_a [4];
   logic         mosi_a [4];
   logic         miso_a [4];
   logic         miso_oe_a [4];
   logic [W-1:0] tx_data_a [4];
   logic         tx_valid_a [4];
   logic         tx_ready_a [4];
   logic [W-1:0] rx_data_a [4];
   logic         rx_valid_a [4];
   logic         rx_ready_a [4];
   logic         busy_a [4];
   logic         overrun_a [4];
   logic         underrun_a [4];
   logic         frame_err_a [4];
   logic         clear_a [4];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_sync #(
         .WIDTH(W), .CPOL(g / 2), .CPHA(g % 2), .LSB_FIRST(g / 2), .SYNC_STAGES(2)
      ) u_dut (
         .clock(clock), .reset(reset),
         .sclk(sclk_a[g]), .ssel(ssel_a[g]), .mosi(mosi_a[g]),
         .miso(miso_a[g]), .miso_oe(miso_oe_a[g]),
         .tx_data(tx_data_a[g]), .tx_valid(tx_valid_a[g]), .tx_ready(tx_ready_a[g]),
         .rx_data(rx_data_a[g]), .rx_valid(rx_valid_a[g]), .rx_ready(rx_ready_a[g]),
         .busy(busy_a[g]), .overrun(overrun_a[g]), .underrun(underrun_a[g]),
         .frame_err(frame_err_a[g]), .clear_flags(clear_a[g])
      );
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tx_load(input int d, input logic [W-1:0] v);
      tx_data_a[d]  = v;
      tx_valid_a[d] = 1'b1;
      wait_clk(1);
      tx_valid_a[d] = 1'b0;
   endtask

   task automatic rx_pop(input int d);
      rx_ready_a[d] = 1'b1;
      wait_clk(1);
      rx_ready_a[d] = 1'b0;
   endtask

   task automatic pulse_clear(input int d);
      clear_a[d] = 1'b1;
      wait_clk(1);
      clear_a[d] = 1'b0;
   endtask

   // Bit-banged SPI master for instance d; returns the bits seen on miso.
   task automatic xfer(input int d, input logic [W-1:0] mw, input int nbits,
                       output logic [W-1:0] sw);
      logic cpol, cpha, lsb;
      int   b;
      cpol = (d >= 2);
      cpha = (d % 2 == 1);
      lsb  = cpol;
      sw   = '0;
      ssel_a[d] = 1'b0;
      wait_clk(H);
      chk("busy_in_frame", {31'd0, busy_a[d]}, 32'd1);
      chk("oe_in_frame", {31'd0, miso_oe_a[d]}, 32'd1);
      for (int k = 0; k < nbits; k++) begin
         b = lsb ? k : W - 1 - k;
         if (!cpha) begin
            mosi_a[d] = mw[b];
            sw[b]     = miso_a[d];
            sclk_a[d] = ~cpol;
            wait_clk(H);
            sclk_a[d] = cpol;
            wait_clk(H);
         end else begin
            sclk_a[d] = ~cpol;
            mosi_a[d] = mw[b];
            wait_clk(H);
            sw[b]     = miso_a[d];
            sclk_a[d] = cpol;
            wait_clk(H);
         end
      end
      ssel_a[d] = 1'b1;
      wait_clk(H);
   endtask

   logic [W-1:0] sw;

   initial begin
      for (int i = 0; i < 4; i++) begin
         sclk_a[i]     = (i >= 2);
         ssel_a[i]     = 1'b1;
         mosi_a[i]     = 1'b0;
         tx_data_a[i]  = '0;
         tx_valid_a[i] = 1'b0;
         rx_ready_a[i] = 1'b0;
         clear_a[i]    = 1'b0;
      end
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(H);

      // Reset state
      chk("rst_miso", {31'd0, miso_a[0]}, 32'd1);
      chk("rst_miso_oe", {31'd0, miso_oe_a[0]}, 32'd0);
      chk("rst_tx_ready", {31'd0, tx_ready_a[0]}, 32'd1);
      chk("rst_rx_valid", {31'd0, rx_valid_a[0]}, 32'd0);
      chk("rst_rx_data", {22'd0, rx_data_a[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy_a[0]}, 32'd0);
      chk("rst_flags", {29'd0, overrun_a[0], underrun_a[0], frame_err_a[0]}, 32'd0);

      // Mode 0 exchange with preloaded transmit word
      tx_load(0, 10'h2A5);
      chk("m0_tx_ready_full", {31'd0, tx_ready_a[0]}, 32'd0);
      xfer(0, 10'h15A, W, sw);
      chk("m0_miso_word", {22'd0, sw}, 32'h2A5);
      chk("m0_rx_data", {22'd0, rx_data_a[0]}, 32'h15A);
      chk("m0_rx_valid", {31'd0, rx_valid_a[0]}, 32'd1);
      chk("m0_flags", {29'd0, overrun_a[0], underrun_a[0], frame_err_a[0]}, 32'd0);
      chk("m0_tx_ready_empty", {31'd0, tx_ready_a[0]}, 32'd1);
      chk("m0_busy_after", {31'd0, busy_a[0]}, 32'd0);
      chk("m0_oe_after", {31'd0, miso_oe_a[0]}, 32'd0);
      rx_pop(0);
      chk("m0_rx_popped", {31'd0, rx_valid_a[0]}, 32'd0);

      // Underrun: empty transmit buffer sends all ones
      xfer(0, 10'h001, W, sw);
      chk("ur_miso_word", {22'd0, sw}, 32'h3FF);
      chk("ur_underrun", {31'd0, underrun_a[0]}, 32'd1);
      chk("ur_rx_data", {22'd0, rx_data_a[0]}, 32'h001);
      rx_pop(0);
      pulse_clear(0);
      chk("ur_cleared", {31'd0, underrun_a[0]}, 32'd0);

      // Overrun: second word discarded while first unread
      xfer(0, 10'h0AA, W, sw);
      xfer(0, 10'h055, W, sw);
      chk("ov_rx_data", {22'd0, rx_data_a[0]}, 32'h0AA);
      chk("ov_overrun", {31'd0, overrun_a[0]}, 32'd1);
      chk("ov_rx_valid", {31'd0, rx_valid_a[0]}, 32'd1);
      pulse_clear(0);
      chk("ov_cleared", {31'd0, overrun_a[0]}, 32'd0);

      // Frame error: ssel released after 4 bits, rx_valid still set from before
      xfer(0, 10'h3C0, 4, sw);
      chk("fe_frame_err", {31'd0, frame_err_a[0]}, 32'd1);
      chk("fe_rx_valid", {31'd0, rx_valid_a[0]}, 32'd1);
      chk("fe_rx_data", {22'd0, rx_data_a[0]}, 32'h0AA);
      rx_pop(0);
      pulse_clear(0);
      chk("fe_cleared", {31'd0, frame_err_a[0]}, 32'd0);
      xfer(0, 10'h3FF, W, sw);
      chk("fe_next_rx", {22'd0, rx_data_a[0]}, 32'h3FF);
      chk("fe_next_no_err", {31'd0, frame_err_a[0]}, 32'd0);
      rx_pop(0);

      // Modes 1..3 (2 and 3 LSB-first)
      for (int d = 1; d < 4; d++) begin
         tx_load(d, 10'h2A5);
         xfer(d, 10'h15A, W, sw);
         chk($sformatf("mode%0d_miso_word", d), {22'd0, sw}, 32'h2A5);
         chk($sformatf("mode%0d_rx_data", d), {22'd0, rx_data_a[d]}, 32'h15A);
         chk($sformatf("mode%0d_rx_valid", d), {31'd0, rx_valid_a[d]}, 32'd1);
         chk($sformatf("mode%0d_underrun", d), {31'd0, underrun_a[d]}, 32'd0);
      end

      // Reset mid-frame with ssel held low
      tx_load(0, 10'h2A5);
      ssel_a[0] = 1'b0;
      wait_clk(H);
      for (int k = 0; k < 2; k++) begin
         sclk_a[0] = 1'b1;
         wait_clk(H);
         sclk_a[0] = 1'b0;
         wait_clk(H);
      end
      reset = 1'b1;
      wait_clk(2);
      chk("mr_miso", {31'd0, miso_a[0]}, 32'd1);
      chk("mr_oe", {31'd0, miso_oe_a[0]}, 32'd0);
      chk("mr_busy", {31'd0, busy_a[0]}, 32'd0);
      chk("mr_tx_ready", {31'd0, tx_ready_a[0]}, 32'd1);
      chk("mr_rx_data", {22'd0, rx_data_a[0]}, 32'd0);
      reset = 1'b0;
      wait_clk(H);
      for (int k = 0; k < 3; k++) begin
         sclk_a[0] = 1'b1;
         wait_clk(H);
         sclk_a[0] = 1'b0;
         wait_clk(H);
      end
      chk("mr_hold_busy", {31'd0, busy_a[0]}, 32'd0);
      chk("mr_hold_oe", {31'd0, miso_oe_a[0]}, 32'd0);
      chk("mr_hold_rx_valid", {31'd0, rx_valid_a[0]}, 32'd0);
      ssel_a[0] = 1'b1;
      wait_clk(H);
      xfer(0, 10'h123, W, sw);
      chk("mr_next_rx", {22'd0, rx_data_a[0]}, 32'h123);
      chk("mr_next_valid", {31'd0, rx_valid_a[0]}, 32'd1);
      chk("mr_next_underrun", {31'd0, underrun_a[0]}, 32'd1);
      chk("mr_next_miso", {22'd0, sw}, 32'h3FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
